// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Definitions shared by the SPI master and its neighbours: the state encoding
// of the transfer FSM and the fixed SPI mode constants (mode 0).
// -----------------------------------------------------------------------------
package spi_pkg;

  // Transfer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // cs_n high, waiting for a word and en
    ST_SHIFT = 2'd1,  // clocking DATA_WIDTH bits
    ST_STORE = 2'd2,  // hand captured word to the RX FIFO, maybe chain next
    ST_HOLD  = 2'd3   // keep cs_n low a little after the last word
  } spi_state_e;

  // SPI mode 0: clock idles low, data sampled on the rising edge
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Chip-select levels
  localparam logic CS_IDLE   = 1'b1;
  localparam logic CS_ACTIVE = 1'b0;

endpackage

// File: rtl/spi_fifo_master.sv
// -----------------------------------------------------------------------------
// spi_fifo_master
// SPI mode-0 master that pulls words from a show-ahead TX FIFO, shifts them out
// MSB first, and pushes the simultaneously received words into an RX FIFO.
// Consecutive words are sent back-to-back with cs_n held low.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   en        permits new transfers to start
//   tx_rdata  head word of the TX FIFO (show-ahead)
//   tx_empty  TX FIFO empty
//   tx_rd     TX FIFO pop strobe
//   rx_wdata  received word for the RX FIFO
//   rx_full   RX FIFO full
//   rx_wr     RX FIFO push strobe
//   sclk      SPI clock
//   mosi      serial data out
//   miso      serial data in
//   cs_n      chip select, active low
//   busy      high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module spi_fifo_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] tx_rdata,
  input  logic                  tx_empty,
  output logic                  tx_rd,
  output logic [DATA_WIDTH-1:0] rx_wdata,
  input  logic                  rx_full,
  output logic                  rx_wr,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  busy
);

  import spi_pkg::*;

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  spi_state_e            state_r;
  logic [DATA_WIDTH-1:0] shreg_r;   // outgoing word, MSB drives mosi
  logic [DATA_WIDTH-1:0] rxsh_r;    // incoming word, miso enters at LSB
  logic [DIV_W-1:0]      div_r;     // clk cycles within an sclk half-period
  logic [BIT_W-1:0]      bit_r;     // completed bits of the current word
  logic                  sclk_r;
  logic                  cs_n_r;
  logic                  pop_s;
  logic                  push_s;

  // FIFO strobes: decoded from state and the FIFO flags so they can never
  // fire against a full/empty FIFO, and are suppressed while in reset.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    if (rst) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pop_s = en & ~tx_empty;
        end
        ST_STORE: begin
          push_s = ~rx_full;
          pop_s  = ~rx_full & en & ~tx_empty;
        end
        default: begin
          pop_s  = 1'b0;
          push_s = 1'b0;
        end
      endcase
    end
  end

  // Transfer FSM with sclk/cs_n generation and the two shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      shreg_r <= '0;
      rxsh_r  <= '0;
      div_r   <= '0;
      bit_r   <= '0;
      sclk_r  <= SPI_CPOL;
      cs_n_r  <= CS_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sclk_r <= SPI_CPOL;
          div_r  <= '0;
          bit_r  <= '0;
          if (pop_s) begin
            shreg_r <= tx_rdata;
            cs_n_r  <= CS_ACTIVE;
            state_r <= ST_SHIFT;
          end else begin
            cs_n_r  <= CS_IDLE;
          end
        end

        ST_SHIFT: begin
          if (div_r == DIV_LAST) begin
            div_r <= '0;
            if (sclk_r == SPI_CPOL) begin
              // Leading (rising) edge: sample miso
              sclk_r <= ~SPI_CPOL;
              rxsh_r <= (rxsh_r << 1) | DATA_WIDTH'(miso);
            end else begin
              // Trailing (falling) edge: present the next bit
              sclk_r  <= SPI_CPOL;
              shreg_r <= shreg_r << 1;
              if (bit_r == BIT_LAST) begin
                bit_r   <= '0;
                state_r <= ST_STORE;
              end else begin
                bit_r   <= bit_r + BIT_W'(1);
              end
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end

        ST_STORE: begin
          // With rx_full high nothing changes: sclk idle, cs_n held low.
          if (push_s) begin
            div_r <= '0;
            if (pop_s) begin
              shreg_r <= tx_rdata;
              state_r <= ST_SHIFT;
            end else begin
              state_r <= ST_HOLD;
            end
          end else begin
            div_r <= '0;
          end
        end

        ST_HOLD: begin
          if (div_r == DIV_LAST) begin
            div_r   <= '0;
            cs_n_r  <= CS_IDLE;
            state_r <= ST_IDLE;
          end else begin
            div_r   <= div_r + DIV_W'(1);
          end
        end

        default: begin
          state_r <= ST_IDLE;
          sclk_r  <= SPI_CPOL;
          cs_n_r  <= CS_IDLE;
          div_r   <= '0;
          bit_r   <= '0;
        end
      endcase
    end
  end

  assign tx_rd    = pop_s;
  assign rx_wr    = push_s;
  assign rx_wdata = rxsh_r;
  assign sclk     = sclk_r;
  assign cs_n     = cs_n_r;
  assign mosi     = shreg_r[DATA_WIDTH-1];
  assign busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_spi_fifo_master.sv
// -----------------------------------------------------------------------------
// tb_spi_fifo_master
// Directed bench for spi_fifo_master (DATA_WIDTH=8, CLK_DIV=2). Small queue
// models stand in for the TX/RX FIFOs; a negedge monitor counts strobes,
// sclk rises, cs_n low cycles and records mosi bits.
// -----------------------------------------------------------------------------
module tb_spi_fifo_master;

  localparam int DW = 8;
  localparam int CD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] tx_rdata;
  logic          tx_empty;
  logic          tx_rd;
  logic [DW-1:0] rx_wdata;
  logic          rx_full;
  logic          rx_wr;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic          cs_n;
  logic          busy;

  logic          miso_loop;
  logic          miso_tie;

  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];

  int            checks = 0;
  int            failures = 0;
  int            rises = 0;
  int            cs_low = 0;
  int            cs_rise = 0;
  int            txrd_cnt = 0;
  int            viol = 0;
  logic [15:0]   mosi_bits = 16'h0000;
  logic          sclk_prev = 1'b0;
  logic          cs_prev = 1'b1;
  logic          pop_pend = 1'b0;

  assign miso = miso_loop ? mosi : miso_tie;

  always #5 clk = ~clk;

  spi_fifo_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tx_rdata (tx_rdata),
    .tx_empty (tx_empty),
    .tx_rd    (tx_rd),
    .rx_wdata (rx_wdata),
    .rx_full  (rx_full),
    .rx_wr    (rx_wr),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tx_refresh();
    tx_empty = (tx_q.size() == 0);
    tx_rdata = (tx_q.size() == 0) ? 8'h00 : tx_q[0];
  endtask

  task automatic tx_push(input logic [DW-1:0] w);
    tx_q.push_back(w);
    tx_refresh();
  endtask

  task automatic tx_pop();
    if (tx_q.size() != 0) begin
      void'(tx_q.pop_front());
    end
    tx_refresh();
  endtask

  task automatic tx_clear();
    tx_q.delete();
    tx_refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    rises     = 0;
    cs_low    = 0;
    cs_rise   = 0;
    txrd_cnt  = 0;
    mosi_bits = 16'h0000;
    rx_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_started"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_finished"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n;
    n = 0;
    while (rises < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rises_reached"}, rises, target);
  endtask

  // FIFO models and event counters, sampled mid-cycle
  always @(negedge clk) begin
    if (pop_pend) tx_pop();
    pop_pend = tx_rd;
    if (tx_rd && tx_empty) viol++;
    if (rx_wr && rx_full) viol++;
    if (rx_wr) rx_q.push_back(rx_wdata);
    if (tx_rd) txrd_cnt++;
    if (sclk && !sclk_prev) begin
      rises++;
      mosi_bits = {mosi_bits[14:0], mosi};
    end
    if (cs_n && !cs_prev) cs_rise++;
    if (!cs_n) cs_low++;
    sclk_prev = sclk;
    cs_prev   = cs_n;
  end

  initial begin
    int stall_bad;
    rst       = 1'b1;
    en        = 1'b0;
    rx_full   = 1'b0;
    miso_loop = 1'b1;
    miso_tie  = 1'b0;
    tx_clear();

    // Reset state, with a word waiting and en high: no pop during reset
    tx_push(8'h11);
    en = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_tx_rd", {31'd0, tx_rd}, 32'd0);
    check_eq("rst_rx_wr", {31'd0, rx_wr}, 32'd0);
    check_eq("rst_cs_n",  {31'd0, cs_n},  32'd1);
    check_eq("rst_sclk",  {31'd0, sclk},  32'd0);
    check_eq("rst_mosi",  {31'd0, mosi},  32'd0);
    check_eq("rst_busy",  {31'd0, busy},  32'd0);
    step();
    en = 1'b0;
    tx_clear();
    rst = 1'b0;
    repeat (2) step();

    // Single word 0xA5, loopback
    clear_counters();
    tx_push(8'hA5);
    en = 1'b1;
    wait_idle("a5");
    repeat (3) step();
    check_eq("a5_tx_rd_count", txrd_cnt, 32'd1);
    check_eq("a5_sclk_rises", rises, 32'd8);
    check_eq("a5_mosi_bits", {24'd0, mosi_bits[7:0]}, 32'hA5);
    check_eq("a5_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check_eq("a5_rx_word", {24'd0, rx_q[0]}, 32'hA5);
    check_eq("a5_cs_low_cycles", cs_low, 32'd35);
    check_eq("a5_cs_rises", cs_rise, 32'd1);

    // Back-to-back 0x3C, 0xC3
    clear_counters();
    tx_push(8'h3C);
    tx_push(8'hC3);
    wait_idle("b2b");
    repeat (3) step();
    check_eq("b2b_tx_rd_count", txrd_cnt, 32'd2);
    check_eq("b2b_sclk_rises", rises, 32'd16);
    check_eq("b2b_mosi_bits", {16'd0, mosi_bits}, 32'h3CC3);
    check_eq("b2b_cs_rises", cs_rise, 32'd1);
    check_eq("b2b_cs_low_cycles", cs_low, 32'd68);
    check_eq("b2b_rx_count", rx_q.size(), 32'd2);
    if (rx_q.size() > 1) begin
      check_eq("b2b_rx_word0", {24'd0, rx_q[0]}, 32'h3C);
      check_eq("b2b_rx_word1", {24'd0, rx_q[1]}, 32'hC3);
    end

    // RX full at end of byte: stall for 10 cycles, then release
    en = 1'b0;
    step();
    clear_counters();
    rx_full = 1'b1;
    tx_push(8'h5A);
    tx_push(8'h96);
    en = 1'b1;
    wait_rises(8, "stall");
    while (sclk) @(negedge clk);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      if (sclk || cs_n || rx_wr || tx_rd || !busy) stall_bad++;
    end
    check_eq("stall_clean_cycles", stall_bad, 32'd0);
    check_eq("stall_tx_rd_count", txrd_cnt, 32'd1);
    check_eq("stall_rx_count", rx_q.size(), 32'd0);
    step();
    rx_full = 1'b0;
    @(negedge clk);
    check_eq("release_rx_wr", {31'd0, rx_wr}, 32'd1);
    check_eq("release_rx_wdata", {24'd0, rx_wdata}, 32'h5A);
    check_eq("release_tx_rd", {31'd0, tx_rd}, 32'd1);
    wait_idle("stall_tail");
    repeat (3) step();
    check_eq("stall_rx_count_end", rx_q.size(), 32'd2);
    if (rx_q.size() > 1) check_eq("stall_rx_word1", {24'd0, rx_q[1]}, 32'h96);

    // Reset after the 3rd sclk rise
    clear_counters();
    tx_push(8'h77);
    wait_rises(3, "midrst");
    step();
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    check_eq("midrst_sclk", {31'd0, sclk}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_mosi", {31'd0, mosi}, 32'd0);
    check_eq("midrst_tx_rd", {31'd0, tx_rd}, 32'd0);
    step();
    rst = 1'b0;
    repeat (40) step();
    check_eq("midrst_rx_count", rx_q.size(), 32'd0);
    check_eq("midrst_tx_rd_count", txrd_cnt, 32'd1);
    check_eq("midrst_tx_left", tx_q.size(), 32'd0);

    // en low with data waiting: nothing happens
    clear_counters();
    tx_push(8'h11);
    repeat (40) step();
    check_eq("en0_tx_rd_count", txrd_cnt, 32'd0);
    check_eq("en0_cs_low_cycles", cs_low, 32'd0);
    check_eq("en0_tx_left", tx_q.size(), 32'd1);

    // en dropped during byte 1 of 2
    tx_push(8'h22);
    en = 1'b1;
    wait_rises(2, "endrop");
    step();
    en = 1'b0;
    wait_idle("endrop");
    repeat (10) step();
    check_eq("endrop_tx_rd_count", txrd_cnt, 32'd1);
    check_eq("endrop_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check_eq("endrop_rx_word", {24'd0, rx_q[0]}, 32'h11);
    check_eq("endrop_tx_left", tx_q.size(), 32'd1);
    check_eq("endrop_tx_head", {24'd0, tx_rdata}, 32'h22);
    tx_clear();

    // miso tied high while sending 0x00
    clear_counters();
    miso_loop = 1'b0;
    miso_tie  = 1'b1;
    tx_push(8'h00);
    en = 1'b1;
    wait_idle("tie1");
    repeat (3) step();
    check_eq("tie1_mosi_bits", {24'd0, mosi_bits[7:0]}, 32'h00);
    check_eq("tie1_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check_eq("tie1_rx_word", {24'd0, rx_q[0]}, 32'hFF);

    // miso tied low while sending 0xFF
    clear_counters();
    miso_tie = 1'b0;
    tx_push(8'hFF);
    wait_idle("tie0");
    repeat (3) step();
    check_eq("tie0_mosi_bits", {24'd0, mosi_bits[7:0]}, 32'hFF);
    check_eq("tie0_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check_eq("tie0_rx_word", {24'd0, rx_q[0]}, 32'h00);

    check_eq("strobe_vs_flag_violations", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_fifo_master.md
SPI_FIFO_MASTER -- requirements
Module: spi_fifo_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per SPI transfer and FIFO word width.
REQ-002 SHALL have parameter CLK_DIV, default 4, legal range >=1, meaning clk cycles per SCLK half-period.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  permits new transfers to start.
REQ-006 SHALL have port tx_rdata  input  DATA_WIDTH  show-ahead head word of TX FIFO.
REQ-007 SHALL have port tx_empty  input  1  TX FIFO empty.
REQ-008 SHALL have port tx_rd  output  1  pop strobe to TX FIFO.
REQ-009 SHALL have port rx_wdata  output  DATA_WIDTH  received word to RX FIFO.
REQ-010 SHALL have port rx_full  input  1  RX FIFO full.
REQ-011 SHALL have port rx_wr  output  1  push strobe to RX FIFO.
REQ-012 SHALL have port sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 SHALL have port mosi  output  1  serial data out, MSB first.
REQ-014 SHALL have port miso  input  1  serial data in, MSB first.
REQ-015 SHALL have port cs_n  output  1  chip select, active-low.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, STORE, HOLD.
REQ-018 In IDLE with en=1 and tx_empty=0, SHALL assert tx_rd combinationally for exactly that cycle, load tx_rdata into the shift register, drive cs_n<=0 and enter SHIFT.
REQ-019 tx_rd SHALL never be asserted while tx_empty=1; rx_wr SHALL never be asserted while rx_full=1.
REQ-020 In SHIFT, each bit SHALL be sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; first rising edge exactly CLK_DIV cycles after cs_n falls.
REQ-021 mosi SHALL equal the shift-register MSB; miso SHALL be sampled on the clk edge where sclk rises; the register shifts left on the sclk falling edge.
REQ-022 After the DATA_WIDTH-th falling edge, sclk SHALL be 0 and FSM SHALL enter STORE; one byte lasts 2*CLK_DIV*DATA_WIDTH cycles.
REQ-023 In STORE with rx_full=1, SHALL stall indefinitely with sclk=0, cs_n=0, no tx_rd, no rx_wr.
REQ-024 In STORE with rx_full=0, SHALL pulse rx_wr for one cycle with rx_wdata = captured word.
REQ-025 In that same STORE cycle, if en=1 and tx_empty=0, SHALL pop the next word per REQ-018 and re-enter SHIFT with cs_n held low (back-to-back); otherwise SHALL enter HOLD.
REQ-026 HOLD SHALL keep cs_n=0 for CLK_DIV cycles, then set cs_n=1 and enter IDLE.
REQ-027 en deasserted mid-transfer SHALL let the current word finish and be stored; no further pop occurs.
REQ-028 Divider counter SHALL be $clog2(CLK_DIV+1) bits; bit counter $clog2(DATA_WIDTH+1) bits; no wrap beyond terminal counts.

Reset
REQ-029 On rst (any state, including mid-transfer), next cycle SHALL have state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, and tx_rd=0, rx_wr=0 during and after reset.
REQ-030 A word popped before a mid-transfer reset SHALL be discarded, with no partial rx_wr.

Structure
REQ-031 State enum typedef and SPI mode constants SHALL live in shared package spi_pkg.
REQ-032 SHALL be a single module with no sub-modules; TX/RX FIFOs are instantiated by the parent.

Verification (DATA_WIDTH=8, CLK_DIV=2)
REQ-033 Load 0xA5, miso looped to mosi, en=1 -> one tx_rd, 8 sclk rises, mosi 1,0,1,0,0,1,0,1, one rx_wr with 0xA5, cs_n low 8*4+1+2 cycles.
REQ-034 Load 0x3C, 0xC3 -> cs_n stays low across both, 16 sclk rises, RX receives 0x3C then 0xC3.
REQ-035 rx_full=1 at end of byte, released 10 cycles later -> sclk=0 and cs_n=0 during stall, rx_wr in release cycle, no tx_rd while stalled.
REQ-036 rst pulsed after 3rd sclk rise -> next cycle cs_n=1, sclk=0, busy=0; no rx_wr.
REQ-037 en=0 with TX nonempty -> tx_rd never asserted, cs_n=1; en dropped during byte 1 of 2 -> byte 1 completes and is stored, byte 2 remains in TX.
REQ-038 miso tied 1 with 0x00 sent -> rx 0xFF; miso tied 0 with 0xFF sent -> rx 0x00.
